// File: rtl/dla_stim_pkg.sv
// Shared types and constants for the dla_stim_gen pseudo-random stimulus source:
// controller states, Galois tap selection per word width and per-lane seeding.
package dla_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stim_state_e;

  // Maximal-length right-shift Galois taps for the supported word widths.
  function automatic logic [31:0] tap_for(input int width);
    logic [31:0] tap;
    case (width)
      8:       tap = 32'h0000_00B8;
      32:      tap = 32'h8020_0003;
      default: tap = 32'h0000_B400;
    endcase
    return tap;
  endfunction

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  function automatic logic [31:0] seed_for(input int base, input int idx, input int width);
    logic [31:0] mask;
    logic [31:0] s;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    s    = 32'(base + idx) & mask;
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

endpackage

// File: rtl/dla_stim_lane.sv
// One stimulus lane: Galois LFSR word source, remaining-word counter and the
// valid/ready transfer logic. The controller loads the counter on an accepted start.
module dla_stim_lane
  import dla_stim_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_len,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_empty_next
);

  localparam logic [31:0]      TAP32 = tap_for(WIDTH);
  localparam logic [WIDTH-1:0] TAP   = TAP32[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             xfer;

  assign xfer = valid_q & i_ready;

  always_comb begin
    lfsr_d = lfsr_q;
    rem_d  = rem_q;
    if (i_load) begin
      rem_d = i_load_len;
    end else if (xfer) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAP : '0);
      rem_d  = rem_q - CNT_W'(1);
    end
    // Valid is registered from the post-edge count so it drops right after the last word.
    valid_d = (rem_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q  <= SEED;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  assign o_data       = lfsr_q;
  assign o_valid      = valid_q;
  assign o_empty_next = (rem_d == '0);

endmodule

// File: rtl/dla_stim_gen.sv
// Bounded, per-lane maskable pseudo-random stimulus source with completion pulse.
// Define DLA_STIM_CHECKSUM_EN to add o_checksum (XOR of all transferred words).
module dla_stim_gen
  import dla_stim_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LANES     = 48,
  parameter int CNT_W     = 16,
  parameter int SEED_BASE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [CNT_W-1:0]       i_burst_len,
  input  logic [LANES-1:0]       i_lane_en,
  input  logic [LANES-1:0]       i_ready,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic [LANES-1:0]       o_valid,
  output logic                   o_busy,
  output logic                   o_done
`ifdef DLA_STIM_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]       o_checksum
`endif
);

  stim_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load;
  logic [LANES-1:0] empty_vec;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          load = 1'b1;
          // A burst with nothing to send completes without ever entering RUN.
          if (i_burst_len == '0 || i_lane_en == '0) state_d = DONE;
          else                                      state_d = RUN;
        end
      end
      RUN:     if (&empty_vec) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [31:0] SEED32 = seed_for(SEED_BASE, i, WIDTH);
    dla_stim_lane #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W),
      .SEED (SEED32[WIDTH-1:0])
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .i_load      (load),
      .i_load_len  (i_lane_en[i] ? i_burst_len : '0),
      .i_ready     (i_ready[i]),
      .o_data      (o_data[i*WIDTH +: WIDTH]),
      .o_valid     (o_valid[i]),
      .o_empty_next(empty_vec[i])
    );
  end

`ifdef DLA_STIM_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (load) begin
      csum_d = '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (o_valid[i] & i_ready[i]) csum_d = csum_d ^ o_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) csum_q <= '0;
    else      csum_q <= csum_d;
  end

  assign o_checksum = csum_q;
`endif

endmodule

// File: tb/tb_dla_stim_gen.sv
// Self-checking bench for dla_stim_gen (WIDTH=16, LANES=4): directed table, corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_dla_stim_gen;

  localparam int WIDTH     = 16;
  localparam int LANES     = 4;
  localparam int CNT_W     = 16;
  localparam int SEED_BASE = 1;
  localparam logic [WIDTH-1:0] TAP = 16'hB400;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_start;
  logic [CNT_W-1:0]       i_burst_len;
  logic [LANES-1:0]       i_lane_en;
  logic [LANES-1:0]       i_ready;
  logic [LANES*WIDTH-1:0] o_data;
  logic [LANES-1:0]       o_valid;
  logic                   o_busy;
  logic                   o_done;
`ifdef DLA_STIM_CHECKSUM_EN
  logic [WIDTH-1:0]       o_checksum;
`endif

  dla_stim_gen #(
    .WIDTH    (WIDTH),
    .LANES    (LANES),
    .CNT_W    (CNT_W),
    .SEED_BASE(SEED_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_burst_len(i_burst_len),
    .i_lane_en  (i_lane_en),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_done     (o_done)
`ifdef DLA_STIM_CHECKSUM_EN
    ,
    .o_checksum (o_checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: word each lane currently shows, words still owed,
  // whether a burst is in flight, and whether this is the completion cycle.
  logic [WIDTH-1:0] m_lfsr[LANES];
  int               m_rem[LANES];
  bit               m_busy;
  bit               m_done;
  logic [WIDTH-1:0] m_csum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] seed(input int i);
    int s;
    s = (SEED_BASE + i) % (1 << WIDTH);
    if (s == 0) s = 1;
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] s);
    int v;
    v = int'(s);
    if (v % 2 == 1) return WIDTH'(v / 2) ^ TAP;
    return WIDTH'(v / 2);
  endfunction

  // Advance the model on the inputs currently applied, clock the DUT, then compare.
  task automatic step();
    logic [WIDTH-1:0]       nl[LANES];
    int                     nr[LANES];
    bit                     nb, nd, left;
    logic [WIDTH-1:0]       nc;
    logic [LANES*WIDTH-1:0] exp_data;
    logic [LANES-1:0]       exp_valid;
    nl = m_lfsr; nr = m_rem; nb = m_busy; nd = 1'b0; nc = m_csum;
    if (rst === 1'b0) begin
      for (int i = 0; i < LANES; i++) begin nl[i] = seed(i); nr[i] = 0; end
      nb = 1'b0; nc = '0;
    end else if (!m_busy && !m_done) begin
      if (i_start) begin
        nc = '0;
        if (i_burst_len != 0 && i_lane_en != 0) begin
          nb = 1'b1;
          for (int i = 0; i < LANES; i++) nr[i] = i_lane_en[i] ? int'(i_burst_len) : 0;
        end else begin
          nd = 1'b1;
        end
      end
    end else if (m_busy) begin
      left = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (nr[i] != 0 && i_ready[i]) begin
          nc    = nc ^ nl[i];
          nl[i] = next_word(nl[i]);
          nr[i] = nr[i] - 1;
        end
        if (nr[i] != 0) left = 1'b1;
      end
      if (!left) begin nb = 1'b0; nd = 1'b1; end
    end
    @(posedge clk);
    #1;
    m_lfsr = nl; m_rem = nr; m_busy = nb; m_done = nd; m_csum = nc;
    for (int i = 0; i < LANES; i++) begin
      exp_data[i*WIDTH +: WIDTH] = m_lfsr[i];
      exp_valid[i] = m_busy && (m_rem[i] != 0);
    end
    check("o_data",  64'(o_data),  64'(exp_data));
    check("o_valid", 64'(o_valid), 64'(exp_valid));
    check("o_busy",  64'(o_busy),  64'(m_busy));
    check("o_done",  64'(o_done),  64'(m_done));
`ifdef DLA_STIM_CHECKSUM_EN
    check("o_checksum", 64'(o_checksum), 64'(m_csum));
`endif
  endtask

  typedef struct {
    bit               start;
    logic [CNT_W-1:0] len;
    logic [LANES-1:0] en;
    logic [LANES-1:0] rdy;
    logic [LANES-1:0] exp_valid;
    logic [WIDTH-1:0] exp_d0;
    bit               exp_busy;
    bit               exp_done;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int cyc;
    bit done_seen;

    tbl[0] = '{1'b1, 16'd3, 4'b0001, 4'b1111, 4'b0001, 16'h0001, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 16'd0, 4'b0000, 4'b1111, 4'b0001, 16'hB400, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'd0, 4'b0000, 4'b1111, 4'b0001, 16'h5A00, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 16'd0, 4'b0000, 4'b1111, 4'b0000, 16'h2D00, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 16'd0, 4'b0000, 4'b1111, 4'b0000, 16'h2D00, 1'b0, 1'b0};

    rst = 1'b0; i_start = 1'b0; i_burst_len = '0; i_lane_en = '0; i_ready = '0;
    for (int i = 0; i < LANES; i++) begin m_lfsr[i] = '0; m_rem[i] = 0; end
    m_busy = 1'b0; m_done = 1'b0; m_csum = '0;
    step();
    step();
    rst = 1'b1;
    check("reset_data", 64'(o_data), 64'h0004_0003_0002_0001);
    check("reset_valid", 64'(o_valid), 64'd0);

    // Directed single-lane burst: len=3 on lane 0 with ready high.
    for (int k = 0; k < 5; k++) begin
      i_start = tbl[k].start; i_burst_len = tbl[k].len;
      i_lane_en = tbl[k].en;  i_ready = tbl[k].rdy;
      step();
      check("tbl_valid", 64'(o_valid), 64'(tbl[k].exp_valid));
      check("tbl_lane0", 64'(o_data[WIDTH-1:0]), 64'(tbl[k].exp_d0));
      check("tbl_busy",  64'(o_busy), 64'(tbl[k].exp_busy));
      check("tbl_done",  64'(o_done), 64'(tbl[k].exp_done));
    end

    // Lane 1 back-pressured every other cycle: completion waits for lane 1.
    i_start = 1'b1; i_burst_len = 16'd4; i_lane_en = 4'b0011; i_ready = 4'b1111;
    step();
    i_start = 1'b0; cyc = 1; done_seen = 1'b0;
    for (int n = 0; n < 40 && !done_seen; n++) begin
      i_ready[1] = (n % 2 == 0);
      step();
      cyc++;
      if (o_done) done_seen = 1'b1;
    end
    check("toggle_done_seen", 64'(done_seen), 64'd1);
    check("toggle_done_cycle", 64'(cyc), 64'd8);
    i_ready = 4'b1111;
    step();

    // Zero-length start completes immediately without asserting busy.
    i_start = 1'b1; i_burst_len = 16'd0; i_lane_en = 4'b1111;
    step();
    i_start = 1'b0;
    check("zero_len_done", 64'(o_done), 64'd1);
    check("zero_len_busy", 64'(o_busy), 64'd0);
    step();

    // Start pulse during RUN is ignored: done after the original 5 words.
    i_start = 1'b1; i_burst_len = 16'd5; i_lane_en = 4'b1111;
    step();
    i_start = 1'b0; cyc = 1; done_seen = 1'b0;
    step(); cyc++;
    i_start = 1'b1; i_burst_len = 16'd9;
    step(); cyc++;
    i_start = 1'b0;
    for (int n = 0; n < 40 && !done_seen; n++) begin
      step();
      cyc++;
      if (o_done) done_seen = 1'b1;
    end
    check("ignore_start_done_seen", 64'(done_seen), 64'd1);
    check("ignore_start_done_cycle", 64'(cyc), 64'd6);
    step();

    // Reset mid-burst abandons the burst and reseeds every lane.
    i_start = 1'b1; i_burst_len = 16'd6; i_lane_en = 4'b1111;
    step();
    i_start = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_data", 64'(o_data), 64'h0004_0003_0002_0001);
    done_seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (o_done) done_seen = 1'b1;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

`ifdef DLA_STIM_CHECKSUM_EN
    // Lane 0 freshly reseeded: two words 0x0001 and 0xB400.
    i_start = 1'b1; i_burst_len = 16'd2; i_lane_en = 4'b0001;
    step();
    i_start = 1'b0; done_seen = 1'b0;
    for (int n = 0; n < 20 && !done_seen; n++) begin
      step();
      if (o_done) done_seen = 1'b1;
    end
    check("csum_done_seen", 64'(done_seen), 64'd1);
    check("csum_value", 64'(o_checksum), 64'h0000_0000_0000_B401);
    step();
`endif

    // Randomized traffic: starts, masks, lengths, back-pressure and occasional resets.
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(0, 59) != 0);
      i_start     = ($urandom_range(0, 3) == 0);
      i_burst_len = CNT_W'($urandom_range(0, 6));
      i_lane_en   = LANES'($urandom);
      i_ready     = LANES'($urandom);
      step();
    end
    rst = 1'b1; i_start = 1'b0; i_ready = 4'b1111;
    for (int n = 0; n < 10; n++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dla_stim_gen.md
# dla_stim_gen

Parametrised pseudo-random stimulus source for DLA-class accelerator benches and FPGA evaluation builds. It generates LANES independent Galois-LFSR word streams, each behind a valid/ready handshake. A start/length/enable command bounds each stream to a fixed burst. It supersedes free-running, unbounded random DDR input generation: a run is bounded, per-lane maskable and back-pressurable, and completion is signalled.

## Interface
- WIDTH, 16: word width per lane; legal values are 8, 16 and 32.
- LANES, 48: number of independent lanes.
- CNT_W, 16: burst-length counter width.
- SEED_BASE, 1: lane i seed = SEED_BASE + i, truncated to WIDTH bits; a zero result is replaced by 1.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- i_start  in  1  command pulse, sampled only in IDLE.
- i_burst_len  in  CNT_W  words per enabled lane, latched on accepted start.
- i_lane_en  in  LANES  per-lane enable, latched on accepted start.
- i_ready  in  LANES  per-lane consumer ready.
- o_data  out  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- o_valid  out  LANES  per-lane word valid.
- o_busy  out  1  high in RUN.
- o_done  out  1  single-cycle completion pulse.
- o_checksum  out  WIDTH  present only with the macro; see Configuration.

## Operation
- Each LFSR steps right-shift Galois: next = (s>>1) ^ (s[0] ? TAP : 0).
- TAP values: 8 bits 0xB8, 16 bits 0xB400, 32 bits 0x80200003.
- The LFSR never reaches zero.
- States are IDLE, RUN and DONE.
- IDLE with i_start=1: latch i_burst_len into every enabled lane's remaining counter (disabled lanes get 0) and go to RUN.
- If i_burst_len=0 or i_lane_en=0, go directly to DONE instead.
- RUN: o_valid[i] = (remaining[i] != 0).
- RUN, transfer when o_valid[i] & i_ready[i]: lane i LFSR advances, remaining[i] decrements.
- Lanes are fully independent; the same edge may carry simultaneous transfers on any subset of lanes.
- RUN → DONE when every remaining counter is 0 after the current edge.
- DONE: o_done=1 for one cycle, then IDLE.
- i_start is ignored in RUN and DONE; there is no queuing.
- LFSR state persists across bursts; only reset reseeds.
- Disabled lanes hold their LFSR and keep o_valid=0.
- o_data is always the current LFSR state, including when o_valid=0.
- Ready without valid has no effect.
- Reset mid-burst: all state is abandoned immediately, LFSRs reseed, state goes to IDLE, and no o_done is issued.

## Timing
- Reset values: state IDLE, o_valid all 0, o_busy 0, o_done 0, o_data[i] = seed_i, o_checksum 0.
- Start accepted at edge k: o_busy and o_valid rise in cycle k+1. The first word is seed_i, or the state carried over from the previous burst.
- Throughput is 1 word/lane/cycle with i_ready held high. A burst of N words completes in N cycles.
- Last transfer at edge t: o_done=1 and o_busy=0 during cycle t+1. i_start is accepted again from edge t+2.
- Zero-length start at edge k: o_done during cycle k+1, o_busy stays 0.
- All outputs are registered; there are no combinational input-to-output paths except none.

## Configuration
- DLA_STIM_CHECKSUM_EN defined:
  - o_checksum exists and holds the XOR of every transferred word on all lanes.
  - It clears on accepted start and updates on each transfer edge.
  - It is stable from the o_done cycle until the next accepted start.
- Not defined: the port, the checksum register and the XOR tree are all absent. Handshake behaviour is identical.

## Structure
- Package dla_stim_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - a function mapping WIDTH to its TAP constant;
  - the seed function (base + index, zero → 1).
- Sub-module dla_stim_lane holds one lane: LFSR, remaining counter, valid and transfer logic. It is instantiated LANES times in a generate loop.
- The top level holds the FSM, the all-lanes-empty reduction and the optional checksum.

## Test plan
- WIDTH=16, LANES=4, SEED_BASE=1; reset, start with len=3 and en=4'b0001, ready high → lane0 emits 0x0001, 0xB400, 0x5A00 on consecutive cycles; o_done on the 4th cycle after start; lanes 1–3 keep valid=0.
- Lane1 ready toggled 1,0,1,0… with len=4 and en=4'b0011 → lane0 finishes in 4 cycles, lane1 in 8; o_done fires only after lane1's last transfer; every lane1 word repeats while ready is low.
- Start with len=0 → o_done the next cycle; o_busy never rises; LFSR states unchanged.
- Pulse i_start during RUN → no effect; the burst count remains as originally latched.
- Drop rst mid-burst → next cycle has o_valid=0 and o_data[i] = seed_i; no o_done.
- With DLA_STIM_CHECKSUM_EN, len=2 and lane0 only → o_checksum = 0x0001 ^ 0xB400 = 0xB401 at o_done.
